// File: rtl/mem_access_unit.sv
// Load/store unit bridging a valid/ready core request port to a single-cycle data memory.
// Define LSU_RANGE_CHECK_EN to reject addresses >= DEPTH with a fault response instead of aliasing.
module mem_access_unit #(
    parameter int DEPTH = 8,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [15:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [15:0]   rsp_rdata,
    output logic          rsp_fault,
    output logic [AW-1:0] mem_access_addr,
    output logic [15:0]   mem_write_data,
    output logic          mem_write_en,
    output logic          mem_read,
    input  logic [15:0]   mem_read_data,
    output logic [15:0]   xact_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RSP  = 2'd3
    } state_t;

`ifdef LSU_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif
    localparam logic [AW-1:0] DEPTH_LIM = AW'(DEPTH);

    state_t        state;
    state_t        state_next;
    logic [15:0]   rdata_q;
    logic [15:0]   rdata_next;
    logic          fault_q;
    logic          fault_next;
    logic [AW-1:0] addr_q;
    logic [15:0]   wdata_q;
    logic [15:0]   count_q;
    logic          accept;
    logic          rsp_done;
    logic          out_of_range;

    assign accept       = req_valid && (state == IDLE);
    assign rsp_done     = (state == RSP) && rsp_ready;
    assign out_of_range = RANGE_CHECK && (req_addr >= DEPTH_LIM);

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        rdata_next = rdata_q;
        fault_next = fault_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (out_of_range) begin
                        state_next = RSP;
                        rdata_next = '0;
                        fault_next = 1'b1;
                    end else begin
                        state_next = req_we ? WR : RD;
                        fault_next = 1'b0;
                    end
                end
            end
            WR: begin
                state_next = RSP;
                rdata_next = '0;
            end
            RD: begin
                state_next = RSP;
                rdata_next = mem_read_data;
            end
            RSP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rdata_q <= '0;
            fault_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
        end else begin
            state   <= state_next;
            rdata_q <= rdata_next;
            fault_q <= fault_next;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (rsp_done) count_q <= count_q + 16'd1;
        end
    end

    // Strobes decode straight from state, so reset removes them without waiting for an edge.
    assign req_ready       = (state == IDLE);
    assign rsp_valid       = (state == RSP);
    assign mem_write_en    = (state == WR);
    assign mem_read        = (state == RD);
    assign mem_access_addr = addr_q;
    assign mem_write_data  = wdata_q;
    assign rsp_rdata       = rdata_q;
    assign rsp_fault       = fault_q;
    assign xact_count      = count_q;

endmodule
